// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues in-order word requests under a credit limit and
// buffers the returned instructions in a small FIFO for decode.
module fetch_stage #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_rdy,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            d_valid,
  input  logic            d_rdy,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0] outstanding_q, outstanding_d, discard_q, discard_d, count_q, count_d;
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [31:0]     data_mem [FIFO_DEPTH];
  logic [XLEN-1:0] pc_mem   [FIFO_DEPTH];

  logic [XLEN-1:0] redirect_pc_al;
  logic            credit, req_fire, push, pop;
  logic            unused_redirect_lsb;

  assign redirect_pc_al      = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // In-flight plus buffered entries may never exceed the buffer size.
  assign credit = ({1'b0, outstanding_q} + {1'b0, count_q}) < (CntW + 1)'(FIFO_DEPTH);

  assign imem_req_valid = !rst && !redirect_valid && credit;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_rdy;

  assign d_valid  = !rst && (count_q != '0);
  assign instr    = d_valid ? data_mem[head_q] : '0;
  assign instr_pc = d_valid ? pc_mem[head_q] : '0;

  assign push = imem_rsp_valid && (discard_q == '0) && !redirect_valid;
  assign pop  = d_valid && d_rdy && !redirect_valid;

  always_comb begin
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    discard_d     = discard_q;
    count_d       = count_q;
    head_d        = head_q;
    tail_d        = tail_q;
    outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(imem_rsp_valid);

    if (redirect_valid) begin
      pc_d     = redirect_pc_al;
      rsp_pc_d = redirect_pc_al;
      count_d  = '0;
      head_d   = '0;
      tail_d   = '0;
      // Every response still in flight belongs to the abandoned path.
      discard_d = outstanding_q - CntW'(imem_rsp_valid);
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(4);
      if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CntW'(1);
      if (push) begin
        rsp_pc_d = rsp_pc_q + XLEN'(4);
        tail_d   = ptr_inc(tail_q);
      end
      if (pop) head_d = ptr_inc(head_q);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[tail_q] <= imem_rsp_data;
      pc_mem[tail_q]   <= rsp_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && (count_q == CntW'(FIFO_DEPTH))))
        else $error("fetch_stage: instruction buffer overflow");
    end
  end

endmodule
